adc_i2c_sampler: RTL and testbench

- Front-end stage feeding the audio-processing chain: periodically reads a 12-bit sample from an AD7991-class I2C ADC and presents it as adc_data with a one-cycle valid strobe.
- On the first transaction after reset it writes a configuration byte to the ADC. After that it performs one read transaction per sample period.
- Implemented as an I2C master with open-drain SCL/SDA, a quarter-bit tick generator and a sample-rate timer.

---
 rtl/adc_i2c_sampler.sv | 190 +++++++++++++++++++
 tb/tb_adc_i2c_sampler.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_i2c_sampler.sv
// rtl/adc_i2c_sampler.sv - I2C master that configures an AD7991-class ADC once, then reads one 12-bit sample per period
module adc_i2c_sampler #(
   parameter int          CLK_DIV    = 63,
   parameter int          SAMPLE_DIV = 12500,
   parameter logic [6:0]  DEV_ADDR   = 7'h28,
   parameter logic [7:0]  CFG_BYTE   = 8'h10
) (
   input  logic        clk,
   input  logic        rst,
   inout  wire         scl,
   inout  wire         sda,
   output logic [11:0] adc_data,
   output logic        adc_valid,
   output logic        ack_err,
   output logic        sample_overrun,
   output logic        busy
);

   localparam int QW = $clog2(CLK_DIV + 1);
   localparam int SW = $clog2(SAMPLE_DIV + 1);
   localparam logic [QW-1:0] Q_LAST = QW'(CLK_DIV - 1);
   localparam logic [SW-1:0] S_LAST = SW'(SAMPLE_DIV - 1);

   // Each byte state is immediately followed by its acknowledge state.
   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_START    = 4'd1;
   localparam logic [3:0] S_ADDR     = 4'd2;
   localparam logic [3:0] S_ADDR_ACK = 4'd3;
   localparam logic [3:0] S_CFG      = 4'd4;
   localparam logic [3:0] S_CFG_ACK  = 4'd5;
   localparam logic [3:0] S_RD_HI    = 4'd6;
   localparam logic [3:0] S_MACK     = 4'd7;
   localparam logic [3:0] S_RD_LO    = 4'd8;
   localparam logic [3:0] S_MNACK    = 4'd9;
   localparam logic [3:0] S_STOP     = 4'd10;

   logic [3:0]    state;
   logic [QW-1:0] qcnt;
   logic [SW-1:0] scnt;
   logic [1:0]    ph;
   logic [2:0]    bcnt;
   logic [7:0]    shreg;
   logic [11:0]   rx;
   logic          ack_bit;
   logic          is_read;
   logic          cfg_done;
   logic          sda_meta;
   logic          sda_s;
   logic          scl_low;
   logic          sda_low;
   logic          scl_low_c;
   logic          sda_low_c;
   logic          qtick;
   logic          stick;

   assign qtick = (qcnt == Q_LAST);
   assign stick = (scnt == S_LAST);
   assign busy  = (state != S_IDLE);

   assign scl = scl_low ? 1'b0 : 1'bz;
   assign sda = sda_low ? 1'b0 : 1'bz;

   // Bus levels per quarter phase; registered below so both lines move on the same edge.
   always_comb begin
      scl_low_c = 1'b0;
      sda_low_c = 1'b0;
      case (state)
         S_IDLE: begin
            scl_low_c = 1'b0;
            sda_low_c = 1'b0;
         end
         S_START: begin
            sda_low_c = (ph != 2'd0);
            scl_low_c = (ph == 2'd3);
         end
         S_STOP: begin
            scl_low_c = (ph == 2'd0);
            sda_low_c = (ph <= 2'd1);
         end
         default: begin
            scl_low_c = (ph == 2'd0) || (ph == 2'd3);
            case (state)
               S_ADDR, S_CFG: sda_low_c = ~shreg[7];
               S_MACK:        sda_low_c = 1'b1;
               default:       sda_low_c = 1'b0;
            endcase
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         qcnt           <= '0;
         scnt           <= '0;
         ph             <= '0;
         bcnt           <= '0;
         shreg          <= '0;
         rx             <= '0;
         ack_bit        <= 1'b0;
         is_read        <= 1'b0;
         cfg_done       <= 1'b0;
         sda_meta       <= 1'b1;
         sda_s          <= 1'b1;
         scl_low        <= 1'b0;
         sda_low        <= 1'b0;
         adc_data       <= '0;
         adc_valid      <= 1'b0;
         ack_err        <= 1'b0;
         sample_overrun <= 1'b0;
      end else begin
         adc_valid      <= 1'b0;
         ack_err        <= 1'b0;
         sample_overrun <= 1'b0;
         sda_meta       <= sda;
         sda_s          <= sda_meta;
         scl_low        <= scl_low_c;
         sda_low        <= sda_low_c;
         scnt           <= stick ? '0 : scnt + 1'b1;

         if (stick && busy)
            sample_overrun <= 1'b1;

         if (state == S_IDLE) begin
            qcnt <= '0;
            ph   <= '0;
            if (stick) begin
               state   <= S_START;
               is_read <= cfg_done;
            end
         end else begin
            qcnt <= qtick ? '0 : qcnt + 1'b1;
            if (qtick) begin
               ph <= ph + 2'd1;
               if (ph == 2'd2) begin
                  ack_bit <= sda_s;
                  // Only the low 12 of the 16 read bits survive the shift, dropping hi[7:4].
                  if (state == S_RD_HI || state == S_RD_LO)
                     rx <= {rx[10:0], sda_s};
               end
               if (ph == 2'd3) begin
                  case (state)
                     S_START: begin
                        state <= S_ADDR;
                        shreg <= {DEV_ADDR, is_read};
                        bcnt  <= '0;
                     end
                     S_ADDR, S_CFG, S_RD_HI, S_RD_LO: begin
                        shreg <= {shreg[6:0], 1'b0};
                        bcnt  <= bcnt + 3'd1;
                        if (bcnt == 3'd7)
                           state <= state + 4'd1;
                     end
                     S_ADDR_ACK: begin
                        if (ack_bit) begin
                           ack_err <= 1'b1;
                           is_read <= 1'b0;
                           state   <= S_STOP;
                        end else if (is_read) begin
                           state <= S_RD_HI;
                        end else begin
                           state <= S_CFG;
                           shreg <= CFG_BYTE;
                        end
                     end
                     S_CFG_ACK: begin
                        if (ack_bit)
                           ack_err <= 1'b1;
                        else
                           cfg_done <= 1'b1;
                        state <= S_STOP;
                     end
                     S_MACK:  state <= S_RD_LO;
                     S_MNACK: state <= S_STOP;
                     S_STOP: begin
                        state <= S_IDLE;
                        if (is_read) begin
                           adc_valid <= 1'b1;
                           adc_data  <= rx;
                        end
                     end
                     default: state <= S_IDLE;
                  endcase
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_adc_i2c_sampler.sv
// tb/tb_adc_i2c_sampler.sv - directed bench with an I2C slave model at 7'h28 on two sampler instances
module tb_adc_i2c_sampler;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_v  [2];
   logic       nack_v [2];
   logic [7:0] hi_v   [2];
   logic [7:0] lo_v   [2];
   int         checks = 0;
   int         errors = 0;
   int         cyc    = 0;
   int         r_cyc  = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic slave_drive(input logic [3:0] i, input logic [1:0] n, input logic rd,
                                        input logic nk, input logic [7:0] h, input logic [7:0] l);
      if (n == 2'd0) return (i == 4'd8) && !nk;
      if (!rd) return (n == 2'd1) && (i == 4'd8);
      if (i == 4'd8) return 1'b0;
      if (n == 2'd1) return !h[3'(4'd7 - i)];
      if (n == 2'd2) return !l[3'(4'd7 - i)];
      return 1'b0;
   endfunction

   // Instance 0 samples every 600 clocks, instance 1 every 300 (shorter than a read).
   for (genvar g = 0; g < 2; g++) begin : env
      wire         scl;
      wire         sda;
      logic [11:0] adc_data;
      logic        adc_valid;
      logic        ack_err;
      logic        sample_overrun;
      logic        busy;
      logic        drv = 1'b0;

      pullup (scl);
      pullup (sda);
      assign sda = (drv && !rst_v[g]) ? 1'b0 : 1'bz;

      adc_i2c_sampler #(
         .CLK_DIV    (4),
         .SAMPLE_DIV (g == 0 ? 600 : 300),
         .DEV_ADDR   (7'h28),
         .CFG_BYTE   (8'h10)
      ) dut (
         .clk            (clk),
         .rst            (rst_v[g]),
         .scl            (scl),
         .sda            (sda),
         .adc_data       (adc_data),
         .adc_valid      (adc_valid),
         .ack_err        (ack_err),
         .sample_overrun (sample_overrun),
         .busy           (busy)
      );

      logic       p_scl = 1'b1, p_sda = 1'b1, in_txn = 1'b0, seen_rise = 1'b0, is_rd = 1'b0;
      logic       mack = 1'b1, mnack = 1'b0;
      logic [3:0] bi = '0;
      logic [1:0] bn = '0;
      logic [7:0] sh = '0, addr_b = '0, cfg_b = '0;
      int         bits = 0, last_bits = 0, nstart = 0, nstop = 0, bad_cnt = 0;
      wire  [3:0] nbi = (bi == 4'd8) ? 4'd0 : bi + 4'd1;
      wire  [1:0] nbn = (bi == 4'd8) ? bn + 2'd1 : bn;

      always @(negedge clk) begin
         p_scl <= scl;
         p_sda <= sda;
         if (rst_v[g]) begin
            in_txn <= 1'b0;
            drv    <= 1'b0;
         end else if (p_scl && scl && p_sda && !sda) begin
            if (in_txn) bad_cnt <= bad_cnt + 1;
            in_txn    <= 1'b1;
            seen_rise <= 1'b0;
            bi        <= '0;
            bn        <= '0;
            bits      <= 0;
            drv       <= 1'b0;
            is_rd     <= 1'b0;
            addr_b    <= '0;
            cfg_b     <= '0;
            mack      <= 1'b1;
            mnack     <= 1'b0;
            nstart    <= nstart + 1;
         end else if (p_scl && scl && !p_sda && sda) begin
            if (in_txn) begin
               last_bits <= bits;
               nstop     <= nstop + 1;
            end
            in_txn <= 1'b0;
            drv    <= 1'b0;
         end else if (in_txn && !p_scl && scl) begin
            seen_rise <= 1'b1;
            sh        <= {sh[6:0], sda};
            if (bi == 4'd7 && bn == 2'd0) begin
               addr_b <= {sh[6:0], sda};
               is_rd  <= sda;
            end
            if (bi == 4'd7 && bn == 2'd1 && !is_rd) cfg_b <= {sh[6:0], sda};
            if (bi == 4'd8 && bn == 2'd1) mack  <= sda;
            if (bi == 4'd8 && bn == 2'd2) mnack <= sda;
         end else if (in_txn && p_scl && !scl) begin
            seen_rise <= 1'b0;
            if (seen_rise) begin
               bits <= bits + 1;
               bi   <= nbi;
               bn   <= nbn;
               drv  <= slave_drive(nbi, nbn, is_rd, nack_v[g], hi_v[g], lo_v[g]);
            end else begin
               drv  <= slave_drive(bi, bn, is_rd, nack_v[g], hi_v[g], lo_v[g]);
            end
         end
      end

      int          cyc_l = 0, t0 = 0, busy_len = 0, last_lat = 0;
      int          valid_cnt = 0, err_cnt = 0, ovr_cnt = 0;
      logic        busy_q = 1'b0;
      logic [11:0] last_data = '0;

      always @(negedge clk) begin
         cyc_l  <= cyc_l + 1;
         busy_q <= busy;
         if (busy && !busy_q) t0 <= cyc_l;
         if (!busy && busy_q) busy_len <= cyc_l - t0;
         if (adc_valid) begin
            valid_cnt <= valid_cnt + 1;
            last_data <= adc_data;
            last_lat  <= cyc_l - t0;
         end
         if (ack_err)        err_cnt <= err_cnt + 1;
         if (sample_overrun) ovr_cnt <= ovr_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_stop0(input int n);
      int budget = 2000;
      while (env[0].nstop < n && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      chk("txn_done", 32'(budget > 0), 32'd1);
      repeat (20) @(negedge clk);
   endtask

   initial begin
      int vcnt;
      int nstop0;
      int budget;
      rst_v[0] = 1'b1;  rst_v[1] = 1'b1;
      nack_v[0] = 1'b1; nack_v[1] = 1'b0;
      hi_v[0] = 8'h0A;  lo_v[0] = 8'hBC;
      hi_v[1] = 8'h05;  lo_v[1] = 8'hA5;
      repeat (4) @(posedge clk);
      #1;
      chk("rst_data",  32'(env[0].adc_data),       32'h000);
      chk("rst_valid", 32'(env[0].adc_valid),      32'd0);
      chk("rst_err",   32'(env[0].ack_err),        32'd0);
      chk("rst_ovr",   32'(env[0].sample_overrun), 32'd0);
      chk("rst_busy",  32'(env[0].busy),           32'd0);
      chk("rst_scl",   32'(env[0].scl),            32'd1);
      chk("rst_sda",   32'(env[0].sda),            32'd1);
      @(negedge clk);
      rst_v[0] = 1'b0;
      rst_v[1] = 1'b0;
      r_cyc = cyc;

      // Address NACKed on the first config attempt.
      wait_stop0(1);
      chk("nack_addr",  32'(env[0].addr_b),    32'h50);
      chk("nack_err",   32'(env[0].err_cnt),   32'd1);
      chk("nack_valid", 32'(env[0].valid_cnt), 32'd0);
      chk("nack_bits",  32'(env[0].last_bits), 32'd9);
      chk("nack_len",   32'(env[0].busy_len),  32'd176);
      nack_v[0] = 1'b0;

      wait_stop0(2);
      chk("cfg_addr",  32'(env[0].addr_b),    32'h50);
      chk("cfg_byte",  32'(env[0].cfg_b),     32'h10);
      chk("cfg_bits",  32'(env[0].last_bits), 32'd18);
      chk("cfg_len",   32'(env[0].busy_len),  32'd320);
      chk("cfg_err",   32'(env[0].err_cnt),   32'd1);
      chk("cfg_valid", 32'(env[0].valid_cnt), 32'd0);

      wait_stop0(3);
      chk("rd1_addr",  32'(env[0].addr_b),    32'h51);
      chk("rd1_valid", 32'(env[0].valid_cnt), 32'd1);
      chk("rd1_data",  32'(env[0].last_data), 32'hABC);
      chk("rd1_hold",  32'(env[0].adc_data),  32'hABC);
      chk("rd1_mack",  32'(env[0].mack),      32'd0);
      chk("rd1_mnack", 32'(env[0].mnack),     32'd1);
      chk("rd1_bits",  32'(env[0].last_bits), 32'd27);
      chk("rd1_lat",   32'(env[0].last_lat),  32'd464);
      chk("rd1_len",   32'(env[0].busy_len),  32'd464);
      hi_v[0] = 8'h30; lo_v[0] = 8'h00;

      wait_stop0(4);
      chk("rd2_valid", 32'(env[0].valid_cnt), 32'd2);
      chk("rd2_data",  32'(env[0].last_data), 32'h000);
      hi_v[0] = 8'hFF; lo_v[0] = 8'hFF;

      while (cyc < r_cyc + 3100) @(negedge clk);
      chk("ovr_count", 32'(env[1].ovr_cnt),   32'd5);
      chk("ovr_valid", 32'(env[1].valid_cnt), 32'd3);
      chk("ovr_data",  32'(env[1].last_data), 32'h5A5);
      chk("ovr_err",   32'(env[1].err_cnt),   32'd0);
      chk("ovr_bad",   32'(env[1].bad_cnt),   32'd0);

      wait_stop0(5);
      chk("rd3_valid", 32'(env[0].valid_cnt), 32'd3);
      chk("rd3_data",  32'(env[0].last_data), 32'hFFF);
      chk("rd3_bits",  32'(env[0].last_bits), 32'd27);

      // Reset while the low byte is being clocked in.
      budget = 2000;
      while (!(env[0].in_txn && env[0].bn == 2'd2) && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      chk("rd_lo_reached", 32'(budget > 0), 32'd1);
      repeat (10) @(negedge clk);
      vcnt = env[0].valid_cnt;
      rst_v[0] = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_scl",   32'(env[0].scl),      32'd1);
      chk("mid_sda",   32'(env[0].sda),      32'd1);
      chk("mid_busy",  32'(env[0].busy),     32'd0);
      chk("mid_data",  32'(env[0].adc_data), 32'h000);
      chk("mid_valid", 32'(env[0].adc_valid), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_v[0] = 1'b0;
      nstop0 = env[0].nstop;
      wait_stop0(nstop0 + 1);
      chk("post_addr",  32'(env[0].addr_b),    32'h50);
      chk("post_cfg",   32'(env[0].cfg_b),     32'h10);
      chk("post_valid", 32'(env[0].valid_cnt), 32'(vcnt));
      chk("post_bad",   32'(env[0].bad_cnt),   32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
